// File: rtl/reg_writeback_unit.sv
// MEM/WB pipeline latch and register-file write-back driver.
// Also tracks outstanding writes per register so decode can detect rs/rt hazards.
module reg_writeback_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PEND_CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] mem_write_reg,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_reg,
  input  logic                  squash_valid,
  input  logic [REG_ADDR_W-1:0] squash_reg,
  input  logic [REG_ADDR_W-1:0] rs_num,
  input  logic [REG_ADDR_W-1:0] rt_num,
  output logic                  rs_pending,
  output logic                  rt_pending,
  output logic                  wb_valid,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] write_reg_num,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  sb_error
);

  localparam int NREG = 1 << REG_ADDR_W;
  localparam int SW   = PEND_CNT_W + 2;
  localparam logic signed [SW-1:0] ONE    = SW'(1);
  localparam logic signed [SW-1:0] ZERO   = '0;
  localparam logic signed [SW-1:0] CMAX_S = SW'((1 << PEND_CNT_W) - 1);

  logic [PEND_CNT_W-1:0] cnt     [NREG];
  logic [PEND_CNT_W-1:0] cnt_nxt [NREG];
  logic                  clip;
  logic                  wb_commit;

  // A held write is only retired once, on the edge where the latch moves on.
  assign wb_commit = regWrite & (~stall | flush);

  assign rs_pending = (cnt[rs_num] != '0);
  assign rt_pending = (cnt[rt_num] != '0);

  always_comb begin
    logic signed [SW-1:0] sum;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    clip       = 1'b0;
    sum        = '0;
    cnt_nxt[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      sum = $signed({2'b00, cnt[i]});
      if (issue_valid && issue_reg == REG_ADDR_W'(i))
        sum = sum + ONE;
      if (wb_commit && write_reg_num == REG_ADDR_W'(i))
        sum = sum - ONE;
      if (squash_valid && squash_reg == REG_ADDR_W'(i))
        sum = sum - ONE;
      if (sum < ZERO) begin
        cnt_nxt[i] = '0;
        clip       = 1'b1;
      end else if (sum > CMAX_S) begin
        cnt_nxt[i] = CMAX_S[PEND_CNT_W-1:0];
        clip       = 1'b1;
      end else begin
        cnt_nxt[i] = sum[PEND_CNT_W-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid      <= 1'b0;
      regWrite      <= 1'b0;
      write_reg_num <= '0;
      write_data    <= '0;
      sb_error      <= 1'b0;
      // NOTE: the counters are flops, not RAM, and must clear so no phantom hazards survive reset.
      for (int i = 0; i < NREG; i++)
        cnt[i] <= '0;
    end else begin
      if (flush) begin
        wb_valid <= 1'b0;
        regWrite <= 1'b0;
      end else if (!stall) begin
        wb_valid      <= mem_valid;
        regWrite      <= mem_valid & mem_reg_write & (mem_write_reg != '0);
        write_reg_num <= mem_write_reg;
        write_data    <= mem_mem_to_reg ? mem_read_data : mem_alu_result;
      end
      for (int i = 0; i < NREG; i++)
        cnt[i] <= cnt_nxt[i];
      if (clip)
        sb_error <= 1'b1;
    end
  end

endmodule
